fetch_pc_unit: RTL and testbench

//   IF-stage PC generator and instruction-fetch sequencer, directly upstream of the branch predictor.

---
 rtl/fetch_pc_unit_if.sv | 37 +++
 rtl/fetch_pc_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
//   SRAM-like instruction-fetch port between the IF-stage PC generator and the
//   instruction memory / cache.
//
//   inst_req      master -> slave   request strobe
//   inst_addr     master -> slave   request address (stable while inst_req=1
//                                   unless the master is redirected)
//   inst_addr_ok  slave  -> master  request accepted this cycle
//   inst_rdata    slave  -> master  returned instruction word
//   inst_data_ok  slave  -> master  inst_rdata valid this cycle
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    // Fetch unit side
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_rdata,
        input  inst_data_ok
    );

    // Instruction memory side
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_rdata,
        output inst_data_ok
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage PC generator and instruction-fetch sequencer. Fetches one
//   instruction at a time over an SRAM-like port and presents pcF/instrF/validF
//   to the branch predictor and the IF/ID register.
//
//   Next-PC priority: exception flush > decode mispredict > predicted-taken
//   target (taken after the delay slot) > sequential pcF+4.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high
//   stallF         in   hold IF; current pcF/instrF are not consumed
//   imem           if   SRAM-like instruction port (master modport)
//   pcF            out  PC of the instruction in instrF
//   instrF         out  fetched instruction
//   validF         out  pcF/instrF hold a live instruction
//   predict_taken  in   branch at pcF predicted taken
//   pc_predict     in   predicted target of the branch at pcF
//   mispredict     in   decode redirect request
//   pc_correct     in   redirect target for mispredict
//   flush_exc      in   exception / eret flush
//   pc_exc         in   handler or EPC address
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stallF,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            pcF,
    output logic [31:0]            instrF,
    output logic                   validF,
    input  logic                   predict_taken,
    input  logic [31:0]            pc_predict,
    input  logic                   mispredict,
    input  logic [31:0]            pc_correct,
    input  logic                   flush_exc,
    input  logic [31:0]            pc_exc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;      // address of the fetch currently in flight
    logic [31:0] pend_tgt;      // predicted target waiting for its delay slot
    logic        pend_tgt_v;
    logic        discard;       // an outstanding response belongs to a dead fetch
    logic        inst_req_r;
    logic [31:0] inst_addr_r;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        take_pred;
    logic [31:0] seq_pc;
    logic [31:0] consume_pc;

    // Sequential successor; wraps modulo 2^32 and ignores alignment, a
    // misaligned PC is reported by a later stage.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    assign imem.inst_req  = inst_req_r;
    assign imem.inst_addr = inst_addr_r;

    always_comb begin
        redirect    = flush_exc | mispredict;
        redirect_pc = flush_exc ? pc_exc : pc_correct;
        take_pred   = validF & predict_taken;
        seq_pc      = pc_plus4(pcF);
        // A predicted-taken branch still fetches its delay slot first; the
        // target is parked in pend_tgt and used on the following consume.
        if (take_pred) begin
            consume_pc = seq_pc;
        end else if (pend_tgt_v) begin
            consume_pc = pend_tgt;
        end else begin
            consume_pc = seq_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            pend_tgt    <= '0;
            pend_tgt_v  <= 1'b0;
            discard     <= 1'b0;
            inst_req_r  <= 1'b0;
            inst_addr_r <= RESET_PC;
            pcF         <= RESET_PC;
            instrF      <= '0;
            validF      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state       <= S_REQ;
                    inst_req_r  <= 1'b1;
                    inst_addr_r <= redirect ? redirect_pc : fetch_pc;
                end

                S_REQ: begin
                    if (imem.inst_addr_ok) begin
                        // Request already accepted: its data will still
                        // come back and has to be thrown away.
                        state      <= S_WAIT;
                        inst_req_r <= 1'b0;
                        if (redirect) begin
                            discard <= 1'b1;
                        end
                    end else if (redirect) begin
                        inst_addr_r <= redirect_pc;
                    end
                end

                S_WAIT: begin
                    if (imem.inst_data_ok) begin
                        if (redirect || discard) begin
                            state       <= S_REQ;
                            discard     <= 1'b0;
                            inst_req_r  <= 1'b1;
                            inst_addr_r <= redirect ? redirect_pc : fetch_pc;
                        end else begin
                            state  <= S_HOLD;
                            pcF    <= fetch_pc;
                            instrF <= imem.inst_rdata;
                            validF <= 1'b1;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        // Redirect overrides both stall and the consume; the
                        // prediction for this slot is not latched.
                        state       <= S_REQ;
                        inst_req_r  <= 1'b1;
                        inst_addr_r <= redirect_pc;
                    end else if (!stallF) begin
                        state       <= S_REQ;
                        fetch_pc    <= consume_pc;
                        validF      <= 1'b0;
                        inst_req_r  <= 1'b1;
                        inst_addr_r <= consume_pc;
                        if (take_pred) begin
                            pend_tgt   <= pc_predict;
                            pend_tgt_v <= 1'b1;
                        end else if (pend_tgt_v) begin
                            pend_tgt_v <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Redirect side effects common to every state; placed last so
            // they take precedence over the per-state updates above.
            if (redirect) begin
                fetch_pc   <= redirect_pc;
                pend_tgt_v <= 1'b0;
                validF     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        validF;
    logic        predict_taken;
    logic [31:0] pc_predict;
    logic        mispredict;
    logic [31:0] pc_correct;
    logic        flush_exc;
    logic [31:0] pc_exc;

    fetch_t sb[$];
    int     total = 0;
    int     bad   = 0;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stallF        (stallF),
        .imem          (bus),
        .pcF           (pcF),
        .instrF        (instrF),
        .validF        (validF),
        .predict_taken (predict_taken),
        .pc_predict    (pc_predict),
        .mispredict    (mispredict),
        .pc_correct    (pc_correct),
        .flush_exc     (flush_exc),
        .pc_exc        (pc_exc)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},    32'(bus.inst_req), 32'd0);
        check({tag, "_addr"},   bus.inst_addr, RST_PC);
        check({tag, "_pcF"},    pcF, RST_PC);
        check({tag, "_instrF"}, instrF, 32'd0);
        check({tag, "_validF"}, 32'(validF), 32'd0);
    endtask

    // Bounded wait for a request, then accept it; returns in WAIT.
    task automatic req_accept(input string tag, input logic [31:0] a);
        int n = 0;
        while (bus.inst_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_req"},  32'(bus.inst_req), 32'd1);
        check({tag, "_addr"}, bus.inst_addr, a);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        check({tag, "_wait_noreq"}, 32'(bus.inst_req), 32'd0);
    endtask

    // Full fetch of address a; returns in HOLD with the result compared.
    task automatic fetch_one(input string tag, input logic [31:0] a);
        fetch_t want;
        req_accept(tag, a);
        sb.push_back({a, mem(a)});
        bus.inst_rdata   = mem(a);
        bus.inst_data_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        check({tag, "_validF"}, 32'(validF), 32'd1);
        if (sb.size() > 0) begin
            want = sb.pop_front();
            check({tag, "_pcF"},    pcF,    want.pc);
            check({tag, "_instrF"}, instrF, want.instr);
        end else begin
            check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    // One clock edge out of HOLD; expect the next request at nxt.
    task automatic consume(input string tag, input logic [31:0] nxt);
        tick();
        check({tag, "_validF_low"}, 32'(validF), 32'd0);
        check({tag, "_req"},        32'(bus.inst_req), 32'd1);
        check({tag, "_next_addr"},  bus.inst_addr, nxt);
    endtask

    task automatic clear_ctl();
        predict_taken = 1'b0;
        mispredict    = 1'b0;
        flush_exc     = 1'b0;
        stallF        = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_ctl();
        pc_predict       = 32'h0;
        pc_correct       = 32'h0;
        pc_exc           = 32'h0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // 1: straight-line zero-wait fetches
        fetch_one("t1_f0", 32'hBFC0_0000);
        consume("t1_c0", 32'hBFC0_0004);
        fetch_one("t1_f1", 32'hBFC0_0004);
        consume("t1_c1", 32'hBFC0_0008);
        fetch_one("t1_f2", 32'hBFC0_0008);
        consume("t1_c2", 32'hBFC0_000C);

        // 2: predicted-taken branch at BFC00010
        fetch_one("t2_f0", 32'hBFC0_000C);
        consume("t2_c0", 32'hBFC0_0010);
        fetch_one("t2_br", 32'hBFC0_0010);
        predict_taken = 1'b1;
        pc_predict    = 32'hBFC0_0100;
        consume("t2_slot", 32'hBFC0_0014);
        predict_taken = 1'b0;
        fetch_one("t2_ds", 32'hBFC0_0014);
        consume("t2_tgt", 32'hBFC0_0100);
        fetch_one("t2_ft", 32'hBFC0_0100);
        consume("t2_c1", 32'hBFC0_0104);

        // 3: mispredict while WAIT, late data discarded
        req_accept("t3_rq", 32'hBFC0_0104);
        mispredict = 1'b1;
        pc_correct = 32'hBFC0_0040;
        tick();
        mispredict = 1'b0;
        check("t3_wait_validF", 32'(validF), 32'd0);
        check("t3_wait_req",    32'(bus.inst_req), 32'd0);
        bus.inst_rdata   = 32'hDEAD_BEEF;
        bus.inst_data_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0;
        check("t3_drop_validF", 32'(validF), 32'd0);
        check("t3_redir_req",   32'(bus.inst_req), 32'd1);
        check("t3_redir_addr",  bus.inst_addr, 32'hBFC0_0040);
        fetch_one("t3_f0", 32'hBFC0_0040);

        // 4: flush_exc + mispredict together, with data_ok in the same cycle,
        //    while a predicted target is pending
        predict_taken = 1'b1;
        pc_predict    = 32'hBFC0_0200;
        consume("t4_slot", 32'hBFC0_0044);
        predict_taken = 1'b0;
        req_accept("t4_rq", 32'hBFC0_0044);
        flush_exc        = 1'b1;
        pc_exc           = 32'hBFC0_0380;
        mispredict       = 1'b1;
        pc_correct       = 32'hBFC0_0040;
        bus.inst_rdata   = 32'h1234_5678;
        bus.inst_data_ok = 1'b1;
        tick();
        clear_ctl();
        bus.inst_data_ok = 1'b0;
        check("t4_validF", 32'(validF), 32'd0);
        check("t4_req",    32'(bus.inst_req), 32'd1);
        check("t4_addr",   bus.inst_addr, 32'hBFC0_0380);
        fetch_one("t4_f0", 32'hBFC0_0380);
        consume("t4_no_pend", 32'hBFC0_0384);

        // 5: stallF held 5 cycles in HOLD
        fetch_one("t5_f0", 32'hBFC0_0384);
        stallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_pcF",    pcF, 32'hBFC0_0384);
            check("t5_instrF", instrF, mem(32'hBFC0_0384));
            check("t5_validF", 32'(validF), 32'd1);
            check("t5_req",    32'(bus.inst_req), 32'd0);
        end
        stallF = 1'b0;
        consume("t5_resume", 32'hBFC0_0388);

        // redirect during a stalled HOLD beats the prediction
        fetch_one("t5b_f0", 32'hBFC0_0388);
        stallF = 1'b1;
        tick();
        mispredict    = 1'b1;
        pc_correct    = 32'hBFC0_0500;
        predict_taken = 1'b1;
        pc_predict    = 32'hBFC0_0900;
        consume("t5b_redir", 32'hBFC0_0500);
        clear_ctl();
        fetch_one("t5b_f1", 32'hBFC0_0500);
        consume("t5b_seq", 32'hBFC0_0504);

        // redirect in REQ without addr_ok retargets the request
        mispredict = 1'b1;
        pc_correct = 32'hBFC0_0600;
        tick();
        mispredict = 1'b0;
        check("req_rt_req",  32'(bus.inst_req), 32'd1);
        check("req_rt_addr", bus.inst_addr, 32'hBFC0_0600);
        fetch_one("req_rt_f", 32'hBFC0_0600);

        // misaligned redirect passes through, sequential PC wraps
        mispredict = 1'b1;
        pc_correct = 32'hFFFF_FFFE;
        consume("wrap_redir", 32'hFFFF_FFFE);
        mispredict = 1'b0;
        fetch_one("wrap_f", 32'hFFFF_FFFE);
        consume("wrap_next", 32'h0000_0002);

        // 6: reset while WAIT, then stale data_ok
        req_accept("t6_rq", 32'h0000_0002);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        tick();
        reset            = 1'b0;
        bus.inst_rdata   = 32'hBAD0_BAD0;
        bus.inst_data_ok = 1'b1;
        tick();
        check("t6_stale_validF", 32'(validF), 32'd0);
        check("t6_req",          32'(bus.inst_req), 32'd1);
        check("t6_addr",         bus.inst_addr, RST_PC);
        tick();
        bus.inst_data_ok = 1'b0;
        check("t6_stale2_validF", 32'(validF), 32'd0);
        check("t6_stale2_req",    32'(bus.inst_req), 32'd1);
        fetch_one("t6_f0", RST_PC);
        consume("t6_c0", 32'hBFC0_0004);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
